muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative 32x32 multiply/divide sequencer with HI/LO
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in FIX.
module muldiv_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] mcand;   // multiplicand or divisor magnitude
  logic [63:0] prod;    // {acc/rem, multiplier/quotient}
  logic        neg_p;
  logic        neg_r;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] pfix;

  always_comb begin
    is_signed = (Op != OP_MULTU) && (Op != OP_DIVU);
    a_neg     = is_signed && A[31];
    b_neg     = is_signed && B[31];
    a_mag     = a_neg ? (32'd0 - A) : A;
    b_mag     = b_neg ? (32'd0 - B) : B;
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {prod[63:32], prod[31]};
    div_ge    = div_shift >= {1'b0, mcand};
    div_sub   = div_shift[31:0] - mcand;
    pfix      = neg_p ? (64'd0 - prod) : prod;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      op_q      <= 3'd0;
      mcand     <= 32'd0;
      prod      <= 64'd0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else if (Flush) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state     <= IDLE;
          Done      <= 1'b0;
          DivByZero <= 1'b0;
          if (Start) begin
            op_q  <= Op;
            cnt   <= 5'd0;
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
            case (Op)
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              OP_DIV, OP_DIVU: begin
                if (B == 32'd0) begin
                  state     <= DONE;
                  Done      <= 1'b1;
                  DivByZero <= 1'b1;
                end else begin
                  state <= DIV;
                  Busy  <= 1'b1;
                  mcand <= b_mag;
                  prod  <= {32'd0, a_mag};
                end
              end
              default: begin
                state <= MUL;
                Busy  <= 1'b1;
                mcand <= a_mag;
                prod  <= {32'd0, b_mag};
              end
            endcase
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[31:1]};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        DIV: begin
          prod <= div_ge ? {div_sub, prod[30:0], 1'b1}
                         : {div_shift[31:0], prod[30:0], 1'b0};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          case (op_q)
            OP_DIV, OP_DIVU: begin
              LO <= neg_p ? (32'd0 - prod[31:0]) : prod[31:0];
              HI <= neg_r ? (32'd0 - prod[63:32]) : prod[63:32];
            end
            OP_MADD: {HI, LO} <= {HI, LO} + pfix;
            OP_MSUB: {HI, LO} <= {HI, LO} - pfix;
            default: {HI, LO} <= pfix;
          endcase
          state <= DONE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  muldiv_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        scoreboard[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model using native wide arithmetic.
  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic signed [63:0] sa, sbv, p, q, r;
    exp_t              e;
    sgn = (op == 3'd0) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    sa  = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sbv = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    e.dbz = 1'b0;
    case (op)
      3'd0, 3'd1: begin p = sa * sbv; {m_hi, m_lo} = p; end
      3'd4: begin p = sa * sbv; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      3'd5: begin p = sa * sbv; {m_hi, m_lo} = {m_hi, m_lo} - p; end
      default: begin
        if (b == 32'd0) e.dbz = 1'b1;
        else begin
          q = sa / sbv;
          r = sa % sbv;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    scoreboard.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(negedge Clk);
    if (!hold) Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int   cyc = 0;
    int   busy = 0;
    exp_t e;
    while (!Done && cyc < 200) begin
      if (Busy) busy++;
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_done"}, Done, 1'b1);
    check({tag, "_busy_cycles"}, busy, exp_busy);
    if (scoreboard.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: got empty expected entry", tag);
    end else begin
      e = scoreboard.pop_front();
      check({tag, "_hilo"}, {HI, LO}, {e.hi, e.lo});
      check({tag, "_dbz"}, DivByZero, e.dbz);
    end
    @(negedge Clk);
    check({tag, "_done_pulse"}, {Done, DivByZero}, 2'b00);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    model_push(op, a, b);
    issue(op, a, b, 1'b0);
    wait_done(tag, ((op == 3'd2 || op == 3'd3) && b == 32'd0) ? 0 : 33);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd6) m_hi = a; else m_lo = a;
    issue(op, a, 32'd0, 1'b0);
    check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
    check({tag, "_idle"}, {Busy, Done}, 2'b00);
  endtask

  logic [2:0] rops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  initial begin
    bit done_seen;
    Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    #1;
    check("reset_outputs", {Busy, Done, DivByZero, HI, LO}, 67'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_const", {HI, LO}, 64'hFFFFFFFE_00000001);
    run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5);
    move_to("mthi", 3'd6, 32'h00000000);
    move_to("mtlo", 3'd7, 32'hFFFFFFFF);
    run("madd", 3'd4, 32'd1, 32'd1);
    check("madd_const", {HI, LO}, 64'h00000001_00000000);
    run("msub", 3'd5, 32'hFFFFFFFE, 32'd3);
    run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    run("divu_zero", 3'd3, 32'd7, 32'd0);
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run("divu", 3'd3, 32'd100, 32'd7);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      op = rops[$urandom_range(0, 5)];
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i == 5) op = 3'd2;
      run($sformatf("rand%0d", i), op, ra, rb);
    end

    // Flush mid-multiply: no completion, HI/LO untouched.
    issue(3'd0, 32'd9, 32'd9, 1'b0);
    repeat (9) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_busy", {Busy, Done, DivByZero}, 3'b000);
    check("flush_hilo", {HI, LO}, {m_hi, m_lo});
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done || Busy) done_seen = 1'b1;
    end
    check("flush_no_done", done_seen, 1'b0);

    // Start held while busy: second op accepted only after first completes.
    model_push(3'd0, 32'd5, 32'hFFFFFFFC);
    model_push(3'd3, 32'd100, 32'd7);
    issue(3'd0, 32'd5, 32'hFFFFFFFC, 1'b1);
    Op = 3'd3; A = 32'd100; B = 32'd7;
    wait_done("held1", 33);
    Start = 1'b0;
    wait_done("held2", 33);

    // Reset during a divide.
    issue(3'd2, 32'd1000, 32'd3, 1'b0);
    repeat (19) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("rst_mid_div", {Busy, Done, HI, LO}, 66'd0);
    #1 Rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge Clk);
    run("mult_after_rst", 3'd0, 32'd6, 32'd7);
    check("mult_after_rst_const", {HI, LO}, 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
